// File: rtl/prog_loader_pkg.sv
// Shared field widths, the stream SYNC byte and the loader state encoding.
package prog_loader_pkg;

    localparam int UNDEFINED     = 3;   // register-select field width
    localparam int CNTR_WIDTH    = 8;
    localparam int ADDR_WIDTH    = 5;   // opcode field width
    localparam int DATA_WIDTH    = 16;
    localparam int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH;

    localparam logic [7:0] LDR_SYNC = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LEN  = 4'd1,
        ST_B2   = 4'd2,
        ST_B1   = 4'd3,
        ST_B0   = 4'd4,
        ST_WR   = 4'd5,
        ST_CSUM = 4'd6,
        ST_DONE = 4'd7,
        ST_ERR  = 4'd8
    } ldr_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and core control of the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    // Stream handshake: a byte moves when in_valid && in_ready at a rising clk edge;
    // in_byte is only meaningful while in_valid=1, and in_ready never waits on in_valid.
    logic                     in_valid;
    logic [7:0]               in_byte;
    logic                     in_ready;
    logic                     mem_we;
    logic [CNTR_WIDTH-1:0]    mem_addr;
    logic [COMBINED_DATA-1:0] mem_wdata;
    logic                     core_rst_n;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output in_valid, in_byte,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err
    );

endinterface

// File: rtl/prog_loader_word_packer.sv
// Packs stream bytes MSB first into an instruction word and keeps a running XOR checksum.
module word_packer
    import prog_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift,
    input  logic                     clear,
    input  logic [7:0]               data,
    output logic [COMBINED_DATA-1:0] word,
    output logic [7:0]               csum
);

    logic [COMBINED_DATA-1:0] word_q;
    logic [7:0]               acc_q;

    // clear seeds the accumulator with the LEN byte, which is part of the checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            acc_q  <= '0;
        end else if (clear) begin
            word_q <= '0;
            acc_q  <= data;
        end else if (shift) begin
            word_q <= {word_q[COMBINED_DATA-9:0], data};
            acc_q  <= acc_q ^ data;
        end
    end

    assign word = word_q;
    assign csum = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Streaming program loader: SYNC/LEN/words/CSUM parser, memory writer and core reset control.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    prog_loader_if.slave   bus,
    output ldr_state_t     dbg_state
);

    ldr_state_t            state_q, state_d;
    logic [CNTR_WIDTH-1:0] len_q;
    logic [CNTR_WIDTH-1:0] addr_q;
    logic [7:0]            csum;
    logic                  in_ready_q, mem_we_q, core_rst_q, busy_q, done_q, err_q;
    logic                  accept;
    logic                  shift, clear;
    logic                  last_word;

    assign accept    = bus.in_valid && in_ready_q;
    assign last_word = (addr_q == len_q);

    word_packer u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (shift),
        .clear (clear),
        .data  (bus.in_byte),
        .word  (bus.mem_wdata),
        .csum  (csum)
    );

    always_comb begin
        state_d = state_q;
        shift   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (accept && bus.in_byte == LDR_SYNC) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (accept) begin
                    clear   = 1'b1;
                    state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (accept) begin
                    shift   = 1'b1;
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                if (accept) begin
                    shift   = 1'b1;
                    state_d = ST_B0;
                end
            end
            ST_B0: begin
                if (accept) begin
                    shift   = 1'b1;
                    state_d = ST_WR;
                end
            end
            ST_WR:   state_d = last_word ? ST_CSUM : ST_B2;
            ST_CSUM: begin
                if (accept) state_d = (bus.in_byte == csum) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_WR);
            mem_we_q   <= (state_d == ST_WR);
            core_rst_q <= (state_d == ST_DONE);
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERR);
            busy_q     <= (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERR);
            if (state_q == ST_LEN && accept) begin
                len_q  <= bus.in_byte;
                addr_q <= '0;
            end else if (state_q == ST_WR && !last_word) begin
                addr_q <= addr_q + CNTR_WIDTH'(1);
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.core_rst_n = core_rst_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader with a stream-level reference model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    ldr_state_t dbg_state;

    prog_loader_if bus ();

    prog_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  stream_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] cap_q[$];
    bit          exp_good;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Capture every memory write; a write cycle must never also accept a byte.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we === 1'b1) begin
            cap_q.push_back({bus.mem_addr, bus.mem_wdata});
            check("wr_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_byte  = 8'($urandom);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget;
        bit rdy;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        budget = 0;
        forever begin
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) break;
            budget++;
            if (budget > 100) begin
                check("accept_timeout", 32'(rdy), 32'd1);
                break;
            end
            @(negedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'($urandom);
    endtask

    task automatic send_stream(input int from, input int gap_pct);
        for (int i = from; i < stream_q.size(); i++) begin
            if ($urandom_range(99) < gap_pct) idle($urandom_range(1, 4));
            send_byte(stream_q[i]);
        end
    endtask

    task automatic make_stream(input int len, input bit good, input bit inject_sync);
        logic [7:0] x, b;
        stream_q.delete();
        stream_q.push_back(LDR_SYNC);
        stream_q.push_back(8'(len));
        x = 8'(len);
        for (int k = 0; k <= len; k++) begin
            for (int j = 0; j < 3; j++) begin
                b = 8'($urandom_range(255));
                if (inject_sync && k == 0 && j == 1) b = LDR_SYNC;
                stream_q.push_back(b);
                x = x ^ b;
            end
        end
        stream_q.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
    endtask

    // Reference model: decode the stream into the writes it implies and its verdict.
    task automatic build_expect();
        int         len;
        logic [7:0] acc;
        exp_q.delete();
        len = int'(stream_q[1]);
        for (int k = 0; k <= len; k++)
            exp_q.push_back({8'(k), stream_q[2+3*k], stream_q[3+3*k], stream_q[4+3*k]});
        acc = 8'h00;
        for (int i = 1; i < stream_q.size() - 1; i++) acc = acc ^ stream_q[i];
        exp_good = (acc == stream_q[stream_q.size()-1]);
    endtask

    task automatic check_load();
        @(negedge clk);
        check("n_writes", 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check("wr_word", cap_q[i], exp_q[i]);
        check("done", 32'(bus.done), 32'(exp_good));
        check("err", 32'(bus.err), 32'(!exp_good));
        check("core_rst_n", 32'(bus.core_rst_n), 32'(exp_good));
        check("busy_end", 32'(bus.busy), 32'd0);
        check("state_end", 32'(dbg_state), exp_good ? 32'(ST_DONE) : 32'(ST_ERR));
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;

        // Reset and idle
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
        send_byte(8'h00);
        send_byte(8'h5A);
        @(negedge clk);
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_no_write", 32'(cap_q.size()), 32'd0);

        // Single-word load, good checksum
        cap_q.delete();
        stream_q = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h70};
        build_expect();
        send_stream(0, 0);
        check_load();
        if (cap_q.size() > 0) check("single_word", cap_q[0], 32'h00123456);

        // Same stream, bad checksum: word still written, core held in reset
        cap_q.delete();
        stream_q = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h71};
        build_expect();
        send_stream(0, 0);
        check_load();

        // SYNC after ERR starts a new load
        cap_q.delete();
        send_byte(LDR_SYNC);
        @(negedge clk);
        check("err_cleared", 32'(bus.err), 32'd0);
        check("busy_after_sync", 32'(bus.busy), 32'd1);
        make_stream(3, 1'b1, 1'b0);
        build_expect();
        send_stream(1, 0);
        check_load();

        // Full 256-word program, back-to-back bytes
        cap_q.delete();
        make_stream(255, 1'b1, 1'b0);
        build_expect();
        send_stream(0, 0);
        check_load();

        // Random lengths, gaps, SYNC bytes in payload, occasional bad checksum
        for (int t = 0; t < 8; t++) begin
            cap_q.delete();
            make_stream($urandom_range(0, 20), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            build_expect();
            send_stream(0, 35);
            check_load();
        end

        // Reset in B1, then reload
        cap_q.delete();
        make_stream(5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(stream_q[i]);
        @(negedge clk);
        check("state_b1", 32'(dbg_state), 32'(ST_B1));
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("no_write_partial", 32'(cap_q.size()), 32'd0);
        make_stream(4, 1'b1, 1'b0);
        build_expect();
        send_stream(0, 20);
        check_load();

        // SYNC in DONE drops core reset the next cycle
        cap_q.delete();
        send_byte(LDR_SYNC);
        @(negedge clk);
        check("core_rst_fall", 32'(bus.core_rst_n), 32'd0);
        check("busy_reload", 32'(bus.busy), 32'd1);
        check("done_cleared", 32'(bus.done), 32'd0);
        make_stream(2, 1'b1, 1'b1);
        build_expect();
        send_stream(1, 10);
        check_load();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Streaming program loader that writes instruction words into the core's instruction memory and holds the core in reset until a valid program is in place. It receives a byte stream through a valid/ready handshake, packs each three bytes into one instruction word (opcode, register field, data), and writes it through the memory's synchronous write port. It checks an XOR checksum at the end of the stream and drives the core's external reset input.

## Interface
- UNDEFINED, 3: register-select field width.
- CNTR_WIDTH, 8: program address width, equal to the program counter width.
- ADDR_WIDTH, 5: opcode field width.
- DATA_WIDTH, 16: immediate/data field width.
- COMBINED_DATA, ADDR_WIDTH+UNDEFINED+DATA_WIDTH (24): instruction word width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_byte is valid.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; a transfer completes when in_valid && in_ready at a clk edge.
- mem_we  out  1  instruction memory write enable, one-cycle pulse.
- mem_addr  out  CNTR_WIDTH  write address.
- mem_wdata  out  COMBINED_DATA  write data as {opcode, reg, data}.
- core_rst_n  out  1  drives the core's rst_ext input; 0 holds the core in reset.
- busy  out  1  a load is in progress.
- done  out  1  the last load completed with a good checksum.
- err  out  1  the last load failed its checksum.

## Operation
- Stream format: SYNC (0xA5), LEN (word count minus 1, 0..255), then LEN+1 words of 3 bytes each, MSB first, then CSUM.
  - CSUM = XOR of LEN and all payload bytes. SYNC is excluded.
- States:
  - IDLE: accepts bytes. Non-SYNC bytes are discarded. SYNC goes to LEN.
  - LEN: latch LEN, clear the address counter and the checksum accumulator, then go to B2.
  - B2, B1, B0: shift a byte into the word register and XOR it into the accumulator. B0 goes to WR.
  - WR: in_ready=0. mem_we=1 with mem_addr=addr and mem_wdata=word.
    - If addr==LEN, go to CSUM.
    - Otherwise addr+1 and go to B2.
  - CSUM: on acceptance, compare the received byte with the accumulator. Match goes to DONE. Mismatch goes to ERR.
  - DONE: accepts bytes. Non-SYNC bytes are discarded. SYNC goes to LEN.
  - ERR: accepts bytes. Non-SYNC bytes are discarded. SYNC goes to LEN.
- Outputs by state:
  - busy=1 in LEN, B2, B1, B0, WR and CSUM.
  - done=1 only in DONE.
  - err=1 only in ERR.
  - core_rst_n=1 only in DONE.
- Address arithmetic is CNTR_WIDTH bits wide. LEN=255 writes addresses 0..255 and terminates by the addr==LEN compare, so it never relies on wrap-around.
- A SYNC byte inside the payload is treated as data; there is no resynchronisation mid-load.
- No writes occur outside WR. A failed checksum does not roll back words already written. The core stays in reset until a later load succeeds.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, busy=0, done=0, err=0, state=IDLE.
- In the first cycle after rst_n deasserts: in_ready=1.
- in_ready=1 in every state except WR.
- Write latency: mem_we is high in the cycle immediately after the B0 byte is accepted, for exactly one cycle. in_ready returns to 1 the cycle after that.
- A word therefore costs at least 4 cycles, and a full load costs at least 4*(LEN+1)+3 cycles.
- In_valid gaps: the loader holds state indefinitely. Partial words and the accumulator are preserved.
- core_rst_n:
  - Rises in the cycle after a matching CSUM byte is accepted.
  - Falls in the cycle after a SYNC is accepted in DONE.
- Asserting rst_n mid-load immediately returns all outputs to their reset values. The next load starts fresh from SYNC.

## Structure
- Shared defines header, alongside the opcode defines:
  - `LDR_SYNC (8'hA5).
  - State encodings (IDLE, LEN, B2, B1, B0, WR, CSUM, DONE, ERR), 4-bit.
- One sub-module: word_packer.
  - 3-byte shift register plus XOR accumulator.
  - Inputs: shift enable, clear, byte.
  - Outputs: COMBINED_DATA word and 8-bit checksum.
- The FSM, address counter and handshake live in the top level.

## Test plan
- Reset and idle:
  - Hold rst_n=0, then check every output is at its reset value.
  - Release rst_n, then check in_ready=1 the next cycle.
  - Feed 0x00 and 0x5A, then check there is no state change and mem_we stays 0.
- Single-word load:
  - Feed A5, 00, 12, 34, 56, 70.
  - Check one mem_we pulse with addr 0x00 and data 0x123456, with in_ready=0 in that cycle.
  - Then check done=1, core_rst_n=1 and busy=0.
- Bad checksum:
  - Same stream with CSUM=0x71.
  - Check err=1, done=0, core_rst_n=0, and that the word at address 0 was still written.
  - Then feed A5, and check err=0 and busy=1.
- Full program:
  - LEN=0xFF with 256 random words, correct CSUM.
  - Check 256 writes at addresses 0..255 in order, with matching data, then DONE.
- Back-pressure and gaps:
  - Drop in_valid randomly mid-word.
  - Check words are assembled correctly and no byte is consumed while in_ready=0 during WR.
- Reset mid-load and reload:
  - Assert rst_n in B1, then check reset values.
  - After a successful load, feed A5, and check core_rst_n=0 the next cycle and busy=1.
